// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: state encoding and default operand width.
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_LOAD  = 2'b01;
    localparam state_t ST_SHIFT = 2'b10;
    localparam state_t ST_DONE  = 2'b11;

endpackage

// File: rtl/serial_add_ctrl_sipo.sv
// Right-shift capture register for sum bits arriving LSB-first.
// o_data_nxt is the value the register takes on the next enabled edge.
module sipo
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_din,
    output logic [WIDTH-1:0] o_data_nxt
);

    logic [WIDTH-1:0] r_data;

    assign o_data_nxt = {i_din, r_data[WIDTH-1:1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= o_data_nxt;
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer for the serial adder: loads both PISOs, shifts WIDTH bits LSB-first,
// tracks the carry and publishes {carry, sum} with a one-cycle done pulse.
//
// state    | meaning
// ST_IDLE  | waiting for start, all controls low
// ST_LOAD  | PISOs parallel-load, carry and bit counter cleared
// ST_SHIFT | one operand bit per cycle, WIDTH cycles
// ST_DONE  | result valid, done pulse
module serial_add_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic           i_sum_bit,
    input  logic           i_cout_bit,
    output logic           o_op_load,
    output logic           o_op_shift,
    output logic           o_carry_q,
    output logic           o_busy,
    output logic           o_done,
    output logic [WIDTH:0] o_sum_out
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_carry_q;
    logic [WIDTH:0]   r_sum_out;
    logic [WIDTH-1:0] w_sipo_nxt;
    logic             w_last;

    assign w_last = (r_bit_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_carry_q <= 1'b0;
            r_sum_out <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_LOAD) begin
                r_carry_q <= 1'b0;
                r_bit_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_carry_q <= i_cout_bit;
                r_bit_cnt <= r_bit_cnt + 1'b1;
                // Final bit goes straight from the adder into the result, bypassing the SIPO.
                if (w_last) begin
                    r_sum_out <= {i_cout_bit, w_sipo_nxt};
                end
            end
        end
    end

    sipo #(
        .WIDTH (WIDTH)
    ) u_sipo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (r_state == ST_SHIFT),
        .i_din      (i_sum_bit),
        .o_data_nxt (w_sipo_nxt)
    );

    assign o_op_load  = (r_state == ST_LOAD);
    assign o_op_shift = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_DONE);
    assign o_carry_q  = r_carry_q;
    assign o_sum_out  = r_sum_out;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: PISO and full-adder models around the sequencer,
// results checked against plain unsigned addition and cycle-count expectations.
module tb_serial_add_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_op = '0;
    logic [W-1:0] b_op = '0;
    logic [W-1:0] pa = '0;
    logic [W-1:0] pb = '0;
    logic         sum_bit, cout_bit;
    logic         op_load, op_shift, carry_q, busy, done;
    logic [W:0]   sum_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W:0] exp_last = '0;

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (op_shift) begin
            if (op_load) begin
                pa <= a_op;
                pb <= b_op;
            end else begin
                pa <= pa >> 1;
                pb <= pb >> 1;
            end
        end
    end

    assign sum_bit  = pa[0] ^ pb[0] ^ carry_q;
    assign cout_bit = (pa[0] & pb[0]) | (pa[0] & carry_q) | (pb[0] & carry_q);

    serial_add_ctrl #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_sum_bit  (sum_bit),
        .i_cout_bit (cout_bit),
        .o_op_load  (op_load),
        .o_op_shift (op_shift),
        .o_carry_q  (carry_q),
        .o_busy     (busy),
        .o_done     (done),
        .o_sum_out  (sum_out)
    );

    // One addition: start pulsed for one edge, optional extra start pulse at edge index poke_k.
    // k counts edges since start was sampled (the sampling edge is k=1).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int poke_k,
                          output logic [W:0] got_sum, output int k_done, output int n_load,
                          output int n_shift, output int n_busy, output int n_done,
                          output logic carry_at_done, output bit stable, output bit idle_after);
        got_sum = 'x; k_done = -1; n_load = 0; n_shift = 0; n_busy = 0; n_done = 0;
        carry_at_done = 1'bx; stable = 1'b1;
        @(negedge clk);
        a_op = a; b_op = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin
                @(negedge clk);
                start = 1'b0;
            end
            n_load  += int'(op_load);
            n_shift += int'(op_shift);
            n_busy  += int'(busy);
            if (done) begin
                n_done++;
                if (k_done < 0) begin
                    k_done = k;
                    got_sum = sum_out;
                    carry_at_done = carry_q;
                end
            end else if (busy && sum_out !== exp_last) begin
                stable = 1'b0;
            end
            if (k == poke_k) start = 1'b1;
        end
        idle_after = !busy && !done && !op_load && !op_shift;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        n_tests++; if (op_load !== 1'b0)  begin n_fail++; $display("FAIL reset_op_load got %b want 0", op_load); end
        n_tests++; if (op_shift !== 1'b0) begin n_fail++; $display("FAIL reset_op_shift got %b want 0", op_shift); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (carry_q !== 1'b0)  begin n_fail++; $display("FAIL reset_carry got %b want 0", carry_q); end
        n_tests++; if (sum_out !== '0)    begin n_fail++; $display("FAIL reset_sum got %b want 0", sum_out); end
        start = 1'b1;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_hold_busy got %b want 0", busy); end
        start = 1'b0;
        rst_n = 1'b1;
        exp_last = '0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int poke_k);
        logic [W:0] s, exp;
        int kd, nl, ns, nb, nd;
        logic cq;
        bit st, idl;
        exp = {1'b0, a} + {1'b0, b};
        run_op(a, b, poke_k, s, kd, nl, ns, nb, nd, cq, st, idl);
        n_tests++; if (s !== exp)     begin n_fail++; $display("FAIL %s sum got %b want %b", name, s, exp); end
        n_tests++; if (kd !== W + 2)  begin n_fail++; $display("FAIL %s done_edge got %0d want %0d", name, kd, W + 2); end
        n_tests++; if (nd !== 1)      begin n_fail++; $display("FAIL %s done_count got %0d want 1", name, nd); end
        n_tests++; if (nl !== 1)      begin n_fail++; $display("FAIL %s load_cycles got %0d want 1", name, nl); end
        n_tests++; if (ns !== W + 1)  begin n_fail++; $display("FAIL %s shift_cycles got %0d want %0d", name, ns, W + 1); end
        n_tests++; if (nb !== W + 2)  begin n_fail++; $display("FAIL %s busy_cycles got %0d want %0d", name, nb, W + 2); end
        n_tests++; if (cq !== exp[W]) begin n_fail++; $display("FAIL %s carry_at_done got %b want %b", name, cq, exp[W]); end
        n_tests++; if (st !== 1'b1)   begin n_fail++; $display("FAIL %s sum_held_while_busy got %b want 1", name, st); end
        n_tests++; if (idl !== 1'b1)  begin n_fail++; $display("FAIL %s idle_after got %b want 1", name, idl); end
        exp_last = exp;
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        a_op = 4'b1011; b_op = 4'b0110; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_tests++; if (op_load !== 1'b0)  begin n_fail++; $display("FAIL midrst_op_load got %b want 0", op_load); end
        n_tests++; if (op_shift !== 1'b0) begin n_fail++; $display("FAIL midrst_op_shift got %b want 0", op_shift); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0)     begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
        n_tests++; if (carry_q !== 1'b0)  begin n_fail++; $display("FAIL midrst_carry got %b want 0", carry_q); end
        n_tests++; if (sum_out !== '0)    begin n_fail++; $display("FAIL midrst_sum got %b want 0", sum_out); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = '0;
        test_directed("after_reset", 4'b1001, 4'b0111, 0);
    endtask

    task automatic test_back_to_back();
        int done_k[$];
        logic [W:0] exp;
        exp = {1'b0, 4'b0101} + {1'b0, 4'b0101};
        @(negedge clk);
        a_op = 4'b0101; b_op = 4'b0101; start = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (k == 2 * (W + 3) + 1) start = 1'b0;
            if (done) begin
                done_k.push_back(k);
                n_tests++;
                if (sum_out !== exp) begin
                    n_fail++; $display("FAIL b2b_sum at edge %0d got %b want %b", k, sum_out, exp);
                end
            end
        end
        start = 1'b0;
        n_tests++;
        if (done_k.size() !== 3) begin
            n_fail++; $display("FAIL b2b_done_count got %0d want 3", done_k.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (done_k[i] !== (W + 2) + i * (W + 3)) begin
                    n_fail++; $display("FAIL b2b_done_edge[%0d] got %0d want %0d", i, done_k[i], (W + 2) + i * (W + 3));
                end
            end
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after got %b want 0", busy); end
        exp_last = exp;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        int poke;
        for (int i = 0; i < 12; i++) begin
            a = W'($urandom_range(0, (1 << W) - 1));
            b = W'($urandom_range(0, (1 << W) - 1));
            poke = (($urandom_range(0, 1)) == 0) ? 0 : int'($urandom_range(2, W + 2));
            test_directed("random", a, b, poke);
        end
    endtask

    initial begin
        test_reset();
        test_directed("basic_13p6", 4'b1101, 4'b0110, 0);
        test_directed("ripple_15p1", 4'b1111, 4'b0001, 0);
        test_directed("zero", 4'b0000, 4'b0000, 0);
        test_directed("start_in_shift", 4'b0011, 4'b0101, 3);
        test_directed("start_in_done", 4'b1110, 4'b0111, W + 2);
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer for the serial adder datapath: two PISO operand registers (A, B), an external combinational full adder, and a carry flip-flop. On `start` it loads both PISOs, shifts WIDTH bits LSB-first, and captures each sum bit into an internal SIPO. It then presents the WIDTH+1-bit result with a one-cycle `done` pulse. It sits above the PISO instances and drives their shared `enable` and `reset` (load) pins.

Parameters:
WIDTH, 4, operand width in bits (≥2); also the number of shift cycles per addition.
CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request a new addition; sampled only in IDLE.
sum_bit  input  1  full-adder sum (A_piso.out ^ B_piso.out ^ carry_q).
cout_bit  input  1  full-adder carry-out.
op_load  output  1  drives PISO `reset` pin (high = parallel load from operand bus).
op_shift  output  1  drives PISO `enable` pin.
carry_q  output  1  registered carry; feeds full-adder carry-in.
busy  output  1  high in LOAD, SHIFT and DONE.
done  output  1  one-cycle pulse; sum_out valid from this cycle onward.
sum_out  output  WIDTH+1  {final carry, sum[WIDTH-1:0]}.

Behaviour:
- Reset (reset=0, async): state=IDLE, bit_cnt=0, carry_q=0, SIPO=0, sum_out=0. All of op_load, op_shift, busy and done are 0. Reset mid-operation aborts with no partial result published.
- States use a 2-bit encoding: IDLE=00, LOAD=01, SHIFT=10, DONE=11.
- IDLE:
  - All control outputs are 0.
  - start=1 at an edge → LOAD.
  - start=0 → stay in IDLE.
- LOAD (1 cycle):
  - op_load=1 and op_shift=1 (PISO load requires enable high).
  - carry_q cleared at the closing edge.
  - bit_cnt cleared at the closing edge.
  - → SHIFT.
- SHIFT (exactly WIDTH cycles):
  - op_shift=1 and op_load=0.
  - At each closing edge: SIPO <= {sum_bit, SIPO[WIDTH-1:1]}, carry_q <= cout_bit, bit_cnt += 1.
  - At bit_cnt==WIDTH-1: transfer to DONE.
  - On that same edge, sum_out <= {cout_bit, sum_bit, SIPO[WIDTH-1:1]}; this includes the final bit.
- DONE (1 cycle):
  - done=1, op_shift=0.
  - → IDLE unconditionally.
- Latency: if start is sampled at edge E0, done is high in the cycle following edge E0+WIDTH+1. For WIDTH=4, that is 6 edges.
- Throughput: with start held high, one result every WIDTH+3 cycles.
- sum_out holds its value until the next DONE transfer or reset. It is never modified during LOAD or SHIFT.
- start outside IDLE is ignored and is not queued.
- Arithmetic is unsigned. Overflow appears as sum_out[WIDTH]; no separate flag.
- Outputs are combinational decodes of the state register only (Moore machine); no input→output paths.

Decomposition:
- Package serial_adder_pkg: state encoding constants (ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE) and default WIDTH, shared with PISO/top-level.
- One natural sub-module: sipo (WIDTH-bit right-shift capture register with enable and async active-low clear), the counterpart to the PISO.
- FSM, counter and carry flip-flop stay in serial_add_ctrl.

Test Plan:
Bench instantiates two PISO models, a full-adder model and this block, with a 20-unit clock.
1. A=4'b1101, B=4'b0110, start pulsed → op_load high for exactly 1 cycle, op_shift high for 5 cycles, done at edge 6 after start, sum_out=5'b10011 (13+6=19).
2. A=4'b1111, B=4'b0001 → carry ripples through all bits; sum_out=5'b10000; carry_q=1 during the DONE cycle.
3. A=0, B=0 → sum_out=5'b00000; done still pulses once at edge 6; busy high for exactly 6 cycles.
4. Start A=4'b0011, B=4'b0101, then pulse start again during SHIFT → second start ignored; single done; sum_out=5'b01000; block returns to IDLE with busy=0.
5. Assert reset low mid-SHIFT (after 2 shifts) → all outputs 0 immediately (asynchronously). After release, run A=4'b1001, B=4'b0111 → sum_out=5'b10000.
6. start held high for 3 operations with constant A=4'b0101, B=4'b0101 → done pulses every 7 cycles; sum_out=5'b01010 each time; no extra or missing pulses.
